// File: rtl/wb_mem_port_arbiter.sv
// Two-master Wishbone-classic arbiter in front of a single memory slave.
// The request and the response are both registered, and a watchdog aborts transfers the slave never acknowledges.
module wb_mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hDEADBEEF)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic [DATA_WIDTH-1:0]   m0_data_i,
  output logic [DATA_WIDTH-1:0]   m0_data_o,
  output logic                    m0_ack_o,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic [DATA_WIDTH-1:0]   m1_data_i,
  output logic [DATA_WIDTH-1:0]   m1_data_o,
  output logic                    m1_ack_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic [DATA_WIDTH-1:0]   s_data_o,
  input  logic [DATA_WIDTH-1:0]   s_data_i,
  input  logic                    s_ack_i,
  output logic [1:0]              grant_o,
  output logic                    timeout_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_last_m1;
  logic [CW-1:0]           r_cnt;
  logic                    r_s_cyc;
  logic                    r_s_stb;
  logic                    r_s_we;
  logic [DATA_WIDTH/8-1:0] r_s_sel;
  logic [ADDR_WIDTH-1:0]   r_s_addr;
  logic [DATA_WIDTH-1:0]   r_s_data;
  logic [DATA_WIDTH-1:0]   r_m0_data;
  logic [DATA_WIDTH-1:0]   r_m1_data;
  logic                    r_m0_ack;
  logic                    r_m1_ack;
  logic [1:0]              r_grant;
  logic                    r_timeout;

  logic                    w_req0;
  logic                    w_req1;
  logic                    w_pick1;
  logic                    w_to_hit;
  logic                    w_finish;
  logic [DATA_WIDTH-1:0]   w_resp_data;

  assign w_req0      = m0_cyc_i & m0_stb_i;
  assign w_req1      = m1_cyc_i & m1_stb_i;
  assign w_to_hit    = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);
  assign w_finish    = s_ack_i | w_to_hit;
  assign w_resp_data = s_ack_i ? s_data_i : ERR_DATA;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and arbitration: m1 wins alone, on a priority tie, or when m0 had the last grant.
  always_comb begin
    w_next  = r_state;
    w_pick1 = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req0 | w_req1) begin
          w_next  = S_BUSY;
          w_pick1 = w_req1 & (~w_req0 | (PRIORITY_MODE == 1) | ~r_last_m1);
        end else begin
          w_next  = S_IDLE;
        end
      end
      S_BUSY: begin
        if (w_finish) begin
          w_next = S_RESP;
        end else begin
          w_next = S_BUSY;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Registered slave request, master responses and watchdog.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last_m1 <= 1'b1;
      r_cnt     <= '0;
      r_s_cyc   <= 1'b0;
      r_s_stb   <= 1'b0;
      r_s_we    <= 1'b0;
      r_s_sel   <= '0;
      r_s_addr  <= '0;
      r_s_data  <= '0;
      r_m0_data <= '0;
      r_m1_data <= '0;
      r_m0_ack  <= 1'b0;
      r_m1_ack  <= 1'b0;
      r_grant   <= 2'b00;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req0 | w_req1) begin
            r_s_cyc   <= 1'b1;
            r_s_stb   <= 1'b1;
            r_s_we    <= w_pick1 ? m1_we_i   : m0_we_i;
            r_s_sel   <= w_pick1 ? m1_sel_i  : m0_sel_i;
            r_s_addr  <= w_pick1 ? m1_addr_i : m0_addr_i;
            r_s_data  <= w_pick1 ? m1_data_i : m0_data_i;
            r_grant   <= w_pick1 ? 2'b10 : 2'b01;
            r_last_m1 <= w_pick1;
            r_cnt     <= '0;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_finish) begin
            r_s_cyc   <= 1'b0;
            r_s_stb   <= 1'b0;
            r_m0_ack  <= r_grant[0];
            r_m1_ack  <= r_grant[1];
            r_timeout <= ~s_ack_i;
            if (r_grant[0]) begin
              r_m0_data <= w_resp_data;
            end
            if (r_grant[1]) begin
              r_m1_data <= w_resp_data;
            end
          end
        end
        S_RESP: begin
          r_m0_ack  <= 1'b0;
          r_m1_ack  <= 1'b0;
          r_timeout <= 1'b0;
          r_grant   <= 2'b00;
        end
        default: begin
          r_grant <= 2'b00;
        end
      endcase
    end
  end

  assign s_cyc_o   = r_s_cyc;
  assign s_stb_o   = r_s_stb;
  assign s_we_o    = r_s_we;
  assign s_sel_o   = r_s_sel;
  assign s_addr_o  = r_s_addr;
  assign s_data_o  = r_s_data;
  assign m0_data_o = r_m0_data;
  assign m1_data_o = r_m1_data;
  assign m0_ack_o  = r_m0_ack;
  assign m1_ack_o  = r_m1_ack;
  assign grant_o   = r_grant;
  assign timeout_o = r_timeout;

endmodule

// File: tb/tb_wb_mem_port_arbiter.sv
// Bench for wb_mem_port_arbiter: a round-robin and a fixed-priority instance, directed steps
// plus random traffic checked against a transfer-level arbitration model.
module tb_wb_mem_port_arbiter;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        m_cyc [2][2];
  logic        m_stb [2][2];
  logic        m_we  [2][2];
  logic [3:0]  m_sel [2][2];
  logic [31:0] m_addr[2][2];
  logic [31:0] m_wdat[2][2];
  logic [31:0] m_rdat[2][2];
  logic        m_ack [2][2];
  logic        s_cyc [2];
  logic        s_stb [2];
  logic        s_we  [2];
  logic [3:0]  s_sel [2];
  logic [31:0] s_addr[2];
  logic [31:0] s_dout[2];
  logic [31:0] s_din [2];
  logic        s_ack [2];
  logic [1:0]  grant [2];
  logic        tmo   [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    wb_mem_port_arbiter #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIORITY_MODE(gi), .TIMEOUT_CYCLES(TO),
      .ERR_DATA(32'hDEADBEEF)
    ) dut (
      .clk_i(clk), .rst_i(rst),
      .m0_cyc_i(m_cyc[gi][0]), .m0_stb_i(m_stb[gi][0]), .m0_we_i(m_we[gi][0]),
      .m0_sel_i(m_sel[gi][0]), .m0_addr_i(m_addr[gi][0]), .m0_data_i(m_wdat[gi][0]),
      .m0_data_o(m_rdat[gi][0]), .m0_ack_o(m_ack[gi][0]),
      .m1_cyc_i(m_cyc[gi][1]), .m1_stb_i(m_stb[gi][1]), .m1_we_i(m_we[gi][1]),
      .m1_sel_i(m_sel[gi][1]), .m1_addr_i(m_addr[gi][1]), .m1_data_i(m_wdat[gi][1]),
      .m1_data_o(m_rdat[gi][1]), .m1_ack_o(m_ack[gi][1]),
      .s_cyc_o(s_cyc[gi]), .s_stb_o(s_stb[gi]), .s_we_o(s_we[gi]), .s_sel_o(s_sel[gi]),
      .s_addr_o(s_addr[gi]), .s_data_o(s_dout[gi]), .s_data_i(s_din[gi]), .s_ack_i(s_ack[gi]),
      .grant_o(grant[gi]), .timeout_o(tmo[gi])
    );
  end

  int ntests = 0;
  int nfail  = 0;
  int lg  [2];
  int mode[2];
  bit pend[2][2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input int m, input logic we, input logic [3:0] sel,
                         input logic [31:0] a, input logic [31:0] d);
    m_cyc[i][m] = 1'b1; m_stb[i][m] = 1'b1; m_we[i][m] = we;
    m_sel[i][m] = sel;  m_addr[i][m] = a;   m_wdat[i][m] = d;
    pend[i][m]  = 1'b1;
  endtask

  task automatic rnd_req(input int i, input int m);
    set_req(i, m, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom);
  endtask

  task automatic drop(input int i, input int m);
    m_cyc[i][m] = 1'b0; m_stb[i][m] = 1'b0; pend[i][m] = 1'b0;
  endtask

  // Arbitration rule: a lone requester wins; on a tie, priority mode favours m1,
  // round-robin favours whoever did not win last.
  function automatic int pick(input int i);
    if (pend[i][0] && pend[i][1]) return (mode[i] == 1) ? 1 : ((lg[i] == 1) ? 0 : 1);
    return pend[i][1] ? 1 : 0;
  endfunction

  // One complete transfer starting from IDLE; lat = BUSY cycle of the slave ack, -1 = never.
  task automatic xfer(input int i, input int lat, input bit rearm, input logic [31:0] rdv,
                      output int w);
    logic [1:0]  eg;
    logic [31:0] ed;
    bit done = 1'b0;
    bit to;
    w  = pick(i);
    eg = (w == 1) ? 2'b10 : 2'b01;
    @(posedge clk); @(negedge clk);
    chk("busy_grant", 32'(grant[i]), 32'(eg));
    chk("busy_cyc",   32'(s_cyc[i]), 32'd1);
    chk("busy_we",    32'(s_we[i]),  32'(m_we[i][w]));
    chk("busy_sel",   32'(s_sel[i]), 32'(m_sel[i][w]));
    chk("busy_addr",  s_addr[i], m_addr[i][w]);
    chk("busy_wdata", s_dout[i], m_wdat[i][w]);
    for (int c = 0; c < TO + 4 && !done; c++) begin
      chk("busy_stb",    32'(s_stb[i]), 32'd1);
      chk("busy_no_ack", 32'({m_ack[i][1], m_ack[i][0]}), 32'd0);
      to = (c != lat) && (c == TO - 1);
      s_din[i] = rdv;
      s_ack[i] = (c == lat);
      @(posedge clk); @(negedge clk);
      s_ack[i] = 1'b0;
      s_din[i] = $urandom;
      if ((c == lat) || to) begin
        done = 1'b1;
        ed = to ? 32'hDEADBEEF : rdv;
        chk("resp_ack",   32'({m_ack[i][1], m_ack[i][0]}), 32'(eg));
        chk("resp_data",  m_rdat[i][w], ed);
        chk("resp_tmo",   32'(tmo[i]), 32'(to));
        chk("resp_cyc",   32'({s_cyc[i], s_stb[i]}), 32'd0);
        chk("resp_grant", 32'(grant[i]), 32'(eg));
        lg[i] = w;
        if (rearm) rnd_req(i, w);
        else drop(i, w);
        @(posedge clk); @(negedge clk);
        chk("idle_grant", 32'(grant[i]), 32'd0);
        chk("idle_ack",   32'({m_ack[i][1], m_ack[i][0]}), 32'd0);
        chk("idle_tmo",   32'(tmo[i]), 32'd0);
      end
    end
    chk("xfer_done", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int w;
    int r;
    rst = 1'b1;
    mode[0] = 0; mode[1] = 1;
    for (int i = 0; i < 2; i++) begin
      lg[i] = 1;
      s_ack[i] = 1'b0; s_din[i] = 32'h0;
      for (int m = 0; m < 2; m++) begin
        m_cyc[i][m] = 1'b0; m_stb[i][m] = 1'b0; m_we[i][m] = 1'b0; m_sel[i][m] = 4'h0;
        m_addr[i][m] = 32'h0; m_wdat[i][m] = 32'h0; pend[i][m] = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ctl",   32'({s_cyc[i], s_stb[i], s_we[i], m_ack[i][0], m_ack[i][1], tmo[i], grant[i]}), 32'd0);
      chk("rst_sel",   32'(s_sel[i]), 32'd0);
      chk("rst_addr",  s_addr[i], 32'd0);
      chk("rst_sdata", s_dout[i], 32'd0);
      chk("rst_m0d",   m_rdat[i][0], 32'd0);
      chk("rst_m1d",   m_rdat[i][1], 32'd0);
    end
    rst = 1'b0;

    // m0 read of 0x100, slave acks two cycles after strobe
    set_req(0, 0, 1'b0, 4'hF, 32'h100, 32'h0);
    xfer(0, 2, 1'b0, 32'h12345678, w);
    chk("t1_winner", 32'(w), 32'd0);

    // m1 write with partial byte selects
    set_req(0, 1, 1'b1, 4'b0011, 32'h2000, 32'hCAFEF00D);
    xfer(0, 0, 1'b0, $urandom, w);
    chk("t4_winner", 32'(w), 32'd1);

    // round-robin with both masters requesting: m0,m1,m0,...
    rnd_req(0, 0); rnd_req(0, 1);
    for (int k = 0; k < 8; k++) begin
      xfer(0, $urandom_range(0, 2), k < 6, $urandom, w);
      chk("rr_order", 32'(w), 32'(k % 2));
    end

    // watchdog: no ack aborts after 8 BUSY cycles; an ack on the 8th cycle wins
    rnd_req(0, 0);
    xfer(0, -1, 1'b0, $urandom, w);
    rnd_req(0, 0);
    xfer(0, TO - 1, 1'b0, 32'h0BADF00D, w);

    // stray ack while idle is ignored
    s_ack[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    s_ack[0] = 1'b0;
    chk("stray_ack", 32'({m_ack[0][1], m_ack[0][0], s_cyc[0], grant[0]}), 32'd0);

    // fixed priority: m1 always wins while it keeps requesting
    rnd_req(1, 0); rnd_req(1, 1);
    for (int k = 0; k < 6; k++) begin
      xfer(1, $urandom_range(0, 3), k < 4, $urandom, w);
      chk("prio_winner", 32'(w), (k < 5) ? 32'd1 : 32'd0);
    end

    // random traffic on both instances
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 25; k++) begin
        for (int m = 0; m < 2; m++) if (!pend[i][m] && ($urandom_range(0, 1) == 1)) rnd_req(i, m);
        if (!pend[i][0] && !pend[i][1]) rnd_req(i, $urandom_range(0, 1));
        r = $urandom_range(0, 6);
        xfer(i, (r == 6) ? -1 : r, 1'b0, $urandom, w);
      end
      for (int k = 0; k < 2 && (pend[i][0] || pend[i][1]); k++) xfer(i, 1, 1'b0, $urandom, w);
    end

    // asynchronous reset in the middle of a BUSY transfer
    rnd_req(0, 0);
    @(posedge clk); @(negedge clk);
    chk("pre_rst_cyc", 32'(s_cyc[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cyc",   32'({s_cyc[0], s_stb[0]}), 32'd0);
    chk("mid_rst_grant", 32'(grant[0]), 32'd0);
    s_ack[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    s_ack[0] = 1'b0;
    chk("mid_rst_noack", 32'({m_ack[0][1], m_ack[0][0]}), 32'd0);
    drop(0, 0);
    rst = 1'b0;
    lg[0] = 1; lg[1] = 1;
    rnd_req(0, 1);
    xfer(0, 1, 1'b0, $urandom, w);
    chk("post_rst_winner", 32'(w), 32'd1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
